// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the reaction timer game: random delay, GO LED, reaction measurement.
// Optional best-time tracking is compiled in when BEST_TIME_EN is defined.
module reaction_round_ctrl #(
  parameter int R_WIDTH   = 12,
  parameter int T_WIDTH   = 10,
  parameter int MIN_DELAY = 500,
  parameter int T_MAX     = 999
) (
  input  logic               clock1,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               react_btn,
  input  logic               ms_tick,
  input  logic [R_WIDTH-1:0] rand_val,
  input  logic               delay_done,
  output logic               delay_load,
  output logic [R_WIDTH-1:0] delay_r,
  output logic               led_go,
  output logic               result_valid,
  output logic [T_WIDTH-1:0] react_time,
  output logic               false_start,
  output logic               timeout,
  output logic               busy,
  output logic [T_WIDTH-1:0] best_time,
  output logic               new_best
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WAIT, ST_MEASURE, ST_SHOW, ST_FALSE
  } state_t;

  state_t             state_q;
  logic               start_prev_q, react_prev_q;
  logic               start_press, react_press;
  logic               delay_load_q, led_go_q, result_valid_q;
  logic               false_start_q, timeout_q, busy_q;
  logic [R_WIDTH-1:0] delay_r_q, delay_r_d;
  logic [T_WIDTH-1:0] react_time_q, count_q;

  assign start_press = start_btn & ~start_prev_q;
  assign react_press = react_btn & ~react_prev_q;
  assign delay_r_d   = (rand_val < R_WIDTH'(MIN_DELAY)) ? R_WIDTH'(MIN_DELAY) : rand_val;

  always_ff @(posedge clock1) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      start_prev_q   <= 1'b0;
      react_prev_q   <= 1'b0;
      delay_load_q   <= 1'b0;
      delay_r_q      <= '0;
      led_go_q       <= 1'b0;
      result_valid_q <= 1'b0;
      react_time_q   <= '0;
      false_start_q  <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      start_prev_q <= start_btn;
      react_prev_q <= react_btn;
      delay_load_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_SHOW, ST_FALSE: begin
          if (start_press) begin
            state_q        <= ST_LOAD;
            delay_load_q   <= 1'b1;
            delay_r_q      <= delay_r_d;
            count_q        <= '0;
            react_time_q   <= '0;
            timeout_q      <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            busy_q         <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Button already held down when the round starts counts as cheating.
          if (react_btn) begin
            state_q       <= ST_FALSE;
            false_start_q <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (react_press) begin
            state_q       <= ST_FALSE;
            false_start_q <= 1'b1;
            busy_q        <= 1'b0;
          end else if (delay_done) begin
            state_q  <= ST_MEASURE;
            led_go_q <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (react_press) begin
            state_q        <= ST_SHOW;
            react_time_q   <= count_q;
            led_go_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
          end else if (ms_tick) begin
            if (count_q == T_WIDTH'(T_MAX - 1)) begin
              state_q        <= ST_SHOW;
              count_q        <= T_WIDTH'(T_MAX);
              react_time_q   <= T_WIDTH'(T_MAX);
              timeout_q      <= 1'b1;
              led_go_q       <= 1'b0;
              busy_q         <= 1'b0;
              result_valid_q <= 1'b1;
            end else begin
              count_q <= count_q + T_WIDTH'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign delay_load   = delay_load_q;
  assign delay_r      = delay_r_q;
  assign led_go       = led_go_q;
  assign result_valid = result_valid_q;
  assign react_time   = react_time_q;
  assign false_start  = false_start_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

`ifdef BEST_TIME_EN
  logic [T_WIDTH-1:0] best_q;
  logic               new_best_q;
  logic               best_hit;

  // Only a genuine press in MEASURE produces a non-timeout result.
  assign best_hit = (state_q == ST_MEASURE) && react_press &&
                    ((best_q == '0) || (count_q < best_q));

  always_ff @(posedge clock1) begin
    if (reset) begin
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else begin
      new_best_q <= best_hit;
      if (best_hit) best_q <= count_q;
    end
  end

  assign best_time = best_q;
  assign new_best  = new_best_q;
`else
  assign best_time = '0;
  assign new_best  = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed and randomized rounds for reaction_round_ctrl checked against a round-level model.
module tb_reaction_round_ctrl;
  localparam int TMAX = 999;
  localparam int MIND = 500;

  logic        clock1 = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0, react_btn = 1'b0, ms_tick = 1'b0, delay_done = 1'b0;
  logic [11:0] rand_val = '0;
  logic        delay_load, led_go, result_valid, false_start, timeout, busy, new_best;
  logic [11:0] delay_r;
  logic [9:0]  react_time, best_time;

  int tests = 0;
  int fails = 0;
  int best  = 0;

  reaction_round_ctrl dut (
    .clock1(clock1), .reset(reset), .start_btn(start_btn), .react_btn(react_btn),
    .ms_tick(ms_tick), .rand_val(rand_val), .delay_done(delay_done),
    .delay_load(delay_load), .delay_r(delay_r), .led_go(led_go),
    .result_valid(result_valid), .react_time(react_time), .false_start(false_start),
    .timeout(timeout), .busy(busy), .best_time(best_time), .new_best(new_best)
  );

  always #5 clock1 = ~clock1;

  task automatic step();
    @(posedge clock1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    $display("[TB] %s: all-zero output check", tag);
    chk({tag, "_load"}, delay_load, 0);
    chk({tag, "_delay_r"}, delay_r, 0);
    chk({tag, "_led"}, led_go, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_rt"}, react_time, 0);
    chk({tag, "_fs"}, false_start, 0);
    chk({tag, "_to"}, timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_best"}, best_time, 0);
    chk({tag, "_newbest"}, new_best, 0);
  endtask

  // Called in the first SHOW cycle with the round's outcome.
  task automatic best_check(input int r, input bit valid);
    bit upd;
    upd = 1'b0;
`ifdef BEST_TIME_EN
    upd = valid && (best == 0 || r < best);
    if (upd) best = r;
`endif
    chk("new_best_pulse", new_best, upd);
    chk("best_time", best_time, best);
  endtask

  // mode: 0 react after ticks, 1 false start in WAIT, 2 press with done,
  //       3 button held through LOAD, 4 no press (timeout), 5 reset mid-MEASURE
  task automatic run_round(input logic [11:0] rv, input int wait_cycles, input int ticks,
                           input int mode, input int gap_max, input bit start_in_meas);
    int  exp_r, cnt, bad;
    bit  timed;
    exp_r = (rv < MIND) ? MIND : rv;
    $display("[TB] round rv=%0d wait=%0d ticks=%0d mode=%0d", rv, wait_cycles, ticks, mode);
    rand_val  = rv;
    start_btn = 1'b1;
    if (mode == 3) react_btn = 1'b1;
    step();
    start_btn = 1'b0;
    rand_val  = 12'($urandom);
    chk("load_pulse", delay_load, 1);
    chk("delay_r", delay_r, exp_r);
    chk("load_busy", busy, 1);
    chk("load_rt_clear", react_time, 0);
    chk("load_to_clear", timeout, 0);
    chk("load_valid_clear", result_valid, 0);
    chk("load_fs_clear", false_start, 0);
    step();
    chk("load_1cycle", delay_load, 0);
    chk("delay_r_hold", delay_r, exp_r);
    if (mode == 3) begin
      chk("held_false", false_start, 1);
      chk("held_busy", busy, 0);
      chk("held_led", led_go, 0);
      react_btn = 1'b0;
      step();
      chk("held_false_hold", false_start, 1);
      return;
    end
    chk("wait_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < wait_cycles; i++) begin
      if (mode == 1 && i == wait_cycles / 2) begin
        react_btn = 1'b1;
        step();
        react_btn = 1'b0;
        chk("wait_led_never", bad, 0);
        chk("wait_false", false_start, 1);
        chk("wait_false_led", led_go, 0);
        chk("wait_false_busy", busy, 0);
        chk("wait_false_rt", react_time, 0);
        step();
        chk("wait_false_hold", false_start, 1);
        return;
      end
      step();
      if (led_go !== 1'b0 || busy !== 1'b1 || delay_load !== 1'b0) bad++;
    end
    chk("wait_outputs", bad, 0);
    delay_done = 1'b1;
    if (mode == 2) react_btn = 1'b1;
    step();
    delay_done = 1'b0;
    if (mode == 2) begin
      react_btn = 1'b0;
      chk("done_press_false", false_start, 1);
      chk("done_press_led", led_go, 0);
      step();
      chk("done_press_led2", led_go, 0);
      return;
    end
    chk("go_led", led_go, 1);
    chk("go_busy", busy, 1);
    cnt = 0;
    timed = 1'b0;
    bad = 0;
    for (int k = 0; k < ((mode == 4) ? TMAX : ticks); k++) begin
      repeat ($urandom_range(0, gap_max)) step();
      if (start_in_meas && k == ticks / 2) begin
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        chk("start_ignored_led", led_go, 1);
        chk("start_ignored_load", delay_load, 0);
      end
      ms_tick = 1'b1;
      step();
      ms_tick = 1'b0;
      cnt++;
      if (cnt == TMAX) begin
        timed = 1'b1;
        break;
      end
      if (led_go !== 1'b1) bad++;
    end
    chk("measure_led", bad, 0);
    if (mode == 5) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      best = 0;
      chk_zero("reset_mid_measure");
      delay_done = 1'b1;
      step();
      delay_done = 1'b0;
      chk("idle_done_ignored_busy", busy, 0);
      chk("idle_done_ignored_led", led_go, 0);
      return;
    end
    if (!timed) begin
      react_btn = 1'b1;
      ms_tick   = 1'($urandom_range(0, 1));
      step();
      react_btn = 1'b0;
      ms_tick   = 1'b0;
    end
    chk("show_valid", result_valid, 1);
    chk("show_led", led_go, 0);
    chk("show_busy", busy, 0);
    chk("show_rt", react_time, timed ? TMAX : cnt);
    chk("show_timeout", timeout, timed);
    chk("show_fs", false_start, 0);
    best_check(cnt, !timed);
    step();
    chk("new_best_1cycle", new_best, 0);
    chk("show_rt_hold", react_time, timed ? TMAX : cnt);
    chk("show_valid_hold", result_valid, 1);
  endtask

  initial begin
    int mode_tab[5] = '{0, 0, 1, 2, 3};
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    chk_zero("idle");

    run_round(12'd1200, 1200, 37, 0, 0, 1'b0);
    run_round(12'd100, 5, 10, 0, 2, 1'b0);
    run_round(12'd0, 5, 12, 0, 1, 1'b0);
    run_round(12'd2000, 20, 0, 1, 0, 1'b0);
    run_round(12'd700, 8, 0, 2, 0, 1'b0);
    run_round(12'd900, 3, 0, 3, 0, 1'b0);
    run_round(12'd1000, 10, 80, 0, 0, 1'b0);
    run_round(12'd1001, 10, 50, 0, 0, 1'b0);
    run_round(12'd1002, 10, 50, 0, 0, 1'b0);
    run_round(12'd1003, 10, 0, 4, 0, 1'b0);
    run_round(12'd600, 4, 30, 0, 1, 1'b1);
    run_round(12'd800, 6, 20, 5, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      run_round(12'($urandom_range(0, 4095)), $urandom_range(1, 30), $urandom_range(1, 150),
                mode_tab[$urandom_range(0, 4)], $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
